vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator for the display path. Produces horizontal and vertical sync, the video-active flag and the current pixel coordinates, plus line/frame start strobes and a frame counter for pixel generators and frame-synchronous logic. Sync polarity and all porch/sync widths are parameters, so one block covers 640x480 and other modes. All outputs are registered and mutually aligned.

## Interface
Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- COORD_W, 12, width of pixel_x/pixel_y
- FRAME_W, 8, width of frame_cnt

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  reset; one clock; asynchronous and active-high
- pix_ce  in  1  pixel advance enable (present only with VGA_TIMING_CE_EN)
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- video_on  out  1  high while (pixel_x, pixel_y) is inside the active area
- pixel_x  out  COORD_W  current column, 0..H_TOTAL-1
- pixel_y  out  COORD_W  current line, 0..V_TOTAL-1
- line_start  out  1  one-pixel pulse at pixel_x==0
- frame_start  out  1  one-pixel pulse at pixel_x==0 and pixel_y==0
- frame_cnt  out  FRAME_W  frame index, increments at each frame_start

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Horizontal counter counts 0..H_TOTAL-1, wraps to 0. Vertical counter advances only on horizontal wrap, counts 0..V_TOTAL-1, wraps to 0 when both wrap together.
- pixel_x/pixel_y are the counter registers. All other outputs are registers loaded from decode of the next counter values, so every output describes the same position in the same cycle.
- video_on = (pixel_x < H_DISPLAY) && (pixel_y < V_DISPLAY).
- hsync active for pixel_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; vsync active for pixel_y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], for whole lines, so it changes only when pixel_x==0.
- frame_cnt wraps modulo 2^FRAME_W; it takes its new value in the same cycle frame_start is high.
- Reset: pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1, video_on=0, hsync=!H_POL, vsync=!V_POL, line_start=0, frame_start=0, frame_cnt=all-ones. The first advance after reset is therefore (0,0), with frame_start=1 and frame_cnt=0.
- Reset asserted mid-frame returns immediately to the reset state. No partial sync pulse is held.
- Elaboration error if any width parameter is 0, or if H_TOTAL or V_TOTAL exceeds 2^COORD_W.

## Timing
- One position per advance. An advance is every clk edge, or every clk edge with pix_ce=1 when the CE feature is enabled.
- The output update is registered: zero extra latency between pixel_x/pixel_y and the sync/flag outputs.
- Default mode: line = 800 advances, frame = 420000 advances. hsync low for pixel_x 656..751; vsync low for pixel_y 490..491.

## Configuration
- VGA_TIMING_CE_EN defined: pix_ce port exists. With pix_ce=0, all registers hold and strobes keep their value for the full stretched pixel. This lets the block run from a faster system clk (e.g. 100 MHz clk, pix_ce every 4th cycle).
- Not defined: no pix_ce port. The block advances every clk; clk must be the pixel clock (25 MHz for 640x480).

## Structure
- Shared package vga_timing_pkg:
  - default 640x480 timing constants;
  - polarity constants SYNC_ACTIVE_LOW/SYNC_ACTIVE_HIGH;
  - H_TOTAL/V_TOTAL helper function.
- Sub-module vga_axis_counter, instantiated twice (horizontal, vertical):
  - inputs: advance and limit;
  - outputs: count, next count and wrap.
- The top level holds the decode registers and frame_cnt.

## Test plan
- Reset release: first cycle reads pixel_x=799, pixel_y=524, video_on=0, hsync=vsync=1. Next cycle reads (0,0), video_on=1, frame_start=1, frame_cnt=0.
- Horizontal sweep on line 0: video_on high for x=0..639. hsync=0 exactly for x=656..751. line_start high only at x=0. After x=799 comes x=0, y=1.
- Vertical sweep over one frame: vsync=0 exactly for y=490..491, switching only at x=0. video_on=0 for y>=480. After (799,524), frame_start=1 and frame_cnt=1.
- Non-default parameters (H_POL=1, V_POL=1, 800x600 with H 40/128/88 and V 1/4/23): active-high syncs; H_TOTAL=1056, V_TOTAL=628.
- VGA_TIMING_CE_EN with pix_ce pulsing 1-in-4: every output holds for 4 clk per pixel; a line lasts 3200 clk.
- Async reset asserted at (300,200) between clk edges: outputs take reset values immediately. Wrap of frame_cnt from 255 to 0 is checked with FRAME_W=8.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480 at 60 Hz on a 25 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Single-bit outputs that are decoded from the next raster position.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
  } vga_flags_t;

  function automatic int unsigned axis_total(input int unsigned display, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to pixel generators.
interface vga_timing_gen_if #(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned FRAME_W = 8
);

  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, frame_cnt
  );

  modport slave (
    input hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis; resets to its limit so that
// the first advance lands on 0.
module vga_axis_counter #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] count_next_o,
  output logic             wrap_o
);

  logic [Width-1:0] count_q, count_d;

  assign wrap_o = advance_i && (count_q == limit_i);

  always_comb begin
    count_d = count_q;
    if (wrap_o) begin
      count_d = '0;
    end else if (advance_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= limit_i;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Defining VGA_TIMING_CE_EN adds a
// pix_ce port so the raster advances only on enabled clk edges.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          H_POL     = SYNC_ACTIVE_LOW,
  parameter bit          V_POL     = SYNC_ACTIVE_LOW,
  parameter int unsigned COORD_W   = 12,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef VGA_TIMING_CE_EN
  input  logic             pix_ce,
`endif
  vga_timing_gen_if.master vga
);

  localparam int unsigned HTotal = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam int unsigned HSyncStart = H_DISPLAY + H_FRONT;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart = V_DISPLAY + V_FRONT;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;

  localparam logic [COORD_W-1:0] HLimit = COORD_W'(HTotal - 1);
  localparam logic [COORD_W-1:0] VLimit = COORD_W'(VTotal - 1);

  if (COORD_W == 0 || FRAME_W == 0 || H_DISPLAY == 0 || H_SYNC == 0 ||
      V_DISPLAY == 0 || V_SYNC == 0) begin : gen_zero_width_err
    $error("vga_timing_gen: width parameters must be non-zero");
  end

  if (64'(HTotal) > (64'(1) << COORD_W) || 64'(VTotal) > (64'(1) << COORD_W))
  begin : gen_coord_w_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COORD_W");
  end

  logic advance;
`ifdef VGA_TIMING_CE_EN
  assign advance = pix_ce;
`else
  assign advance = 1'b1;
`endif

  logic [COORD_W-1:0] h_count, h_next;
  logic [COORD_W-1:0] v_count, v_next;
  logic               h_wrap, v_wrap;

  vga_axis_counter #(
    .Width(COORD_W)
  ) u_h_counter (
    .clk         (clk),
    .rst         (rst),
    .advance_i   (advance),
    .limit_i     (HLimit),
    .count_o     (h_count),
    .count_next_o(h_next),
    .wrap_o      (h_wrap)
  );

  // The vertical axis steps once per completed line.
  vga_axis_counter #(
    .Width(COORD_W)
  ) u_v_counter (
    .clk         (clk),
    .rst         (rst),
    .advance_i   (h_wrap),
    .limit_i     (VLimit),
    .count_o     (v_count),
    .count_next_o(v_next),
    .wrap_o      (v_wrap)
  );

  vga_flags_t         flags_q, flags_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               hsync_act, vsync_act;

  // Flags decode the counters' next values so they line up with pixel_x/pixel_y.
  always_comb begin
    flags_d     = flags_q;
    frame_cnt_d = frame_cnt_q;
    hsync_act   = (32'(h_next) >= HSyncStart) && (32'(h_next) < HSyncEnd);
    vsync_act   = (32'(v_next) >= VSyncStart) && (32'(v_next) < VSyncEnd);
    if (advance) begin
      flags_d.hsync       = hsync_act ? H_POL : !H_POL;
      flags_d.vsync       = vsync_act ? V_POL : !V_POL;
      flags_d.video_on    = (32'(h_next) < H_DISPLAY) && (32'(v_next) < V_DISPLAY);
      flags_d.line_start  = (h_next == '0);
      flags_d.frame_start = (h_next == '0) && (v_next == '0);
      if (flags_d.frame_start) begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q.hsync       <= !H_POL;
      flags_q.vsync       <= !V_POL;
      flags_q.video_on    <= 1'b0;
      flags_q.line_start  <= 1'b0;
      flags_q.frame_start <= 1'b0;
      frame_cnt_q         <= '1;
    end else begin
      flags_q     <= flags_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

  assign vga.hsync       = flags_q.hsync;
  assign vga.vsync       = flags_q.vsync;
  assign vga.video_on    = flags_q.video_on;
  assign vga.line_start  = flags_q.line_start;
  assign vga.frame_start = flags_q.frame_start;
  assign vga.pixel_x     = h_count;
  assign vga.pixel_y     = v_count;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, 800x600 active-high and
// a tiny active-high mode that makes frame_cnt wrap within a short run.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_CE_EN
  localparam int Div = 4;
  localparam int NPos = 1700;
`else
  localparam int Div = 1;
  localparam int NPos = 35842;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VGA_TIMING_CE_EN
  logic pix_ce_r;
`endif

  vga_timing_gen_if #(.COORD_W(12), .FRAME_W(8)) def_if ();
  vga_timing_gen_if #(.COORD_W(12), .FRAME_W(8)) big_if ();
  vga_timing_gen_if #(.COORD_W(12), .FRAME_W(8)) sml_if ();

  vga_timing_gen u_def (
    .clk   (clk),
    .rst   (rst),
`ifdef VGA_TIMING_CE_EN
    .pix_ce(pix_ce_r),
`endif
    .vga   (def_if)
  );

  vga_timing_gen #(
    .H_DISPLAY(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_DISPLAY(600), .V_FRONT(1),  .V_SYNC(4),   .V_BACK(23),
    .H_POL(1'b1), .V_POL(1'b1), .COORD_W(12), .FRAME_W(8)
  ) u_big (
    .clk   (clk),
    .rst   (rst),
`ifdef VGA_TIMING_CE_EN
    .pix_ce(pix_ce_r),
`endif
    .vga   (big_if)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .H_POL(1'b1), .V_POL(1'b1), .COORD_W(12), .FRAME_W(8)
  ) u_sml (
    .clk   (clk),
    .rst   (rst),
`ifdef VGA_TIMING_CE_EN
    .pix_ce(pix_ce_r),
`endif
    .vga   (sml_if)
  );

  // {hsync, vsync, video_on, line_start, frame_start, frame_cnt[7:0], x[11:0], y[11:0]}
  logic [36:0] def_vec, big_vec, sml_vec;
  assign def_vec = {def_if.hsync, def_if.vsync, def_if.video_on, def_if.line_start,
                    def_if.frame_start, def_if.frame_cnt, def_if.pixel_x, def_if.pixel_y};
  assign big_vec = {big_if.hsync, big_if.vsync, big_if.video_on, big_if.line_start,
                    big_if.frame_start, big_if.frame_cnt, big_if.pixel_x, big_if.pixel_y};
  assign sml_vec = {sml_if.hsync, sml_if.vsync, sml_if.video_on, sml_if.line_start,
                    sml_if.frame_start, sml_if.frame_cnt, sml_if.pixel_x, sml_if.pixel_y};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Closed-form raster position for advance number p (p = 0 is the first pixel).
  function automatic logic [36:0] raster(input int p, input int hd, input int hf, input int hs,
                                         input int hb, input int vd, input int vf, input int vs,
                                         input int vb, input bit hp, input bit vp);
    int  ht, vt, x, y, f;
    bit  h_on, v_on;
    ht   = hd + hf + hs + hb;
    vt   = vd + vf + vs + vb;
    x    = p % ht;
    y    = (p / ht) % vt;
    f    = (p / (ht * vt)) % 256;
    h_on = (x >= hd + hf) && (x < hd + hf + hs);
    v_on = (y >= vd + vf) && (y < vd + vf + vs);
    return {h_on ? hp : !hp, v_on ? vp : !vp, (x < hd) && (y < vd), x == 0,
            (x == 0) && (y == 0), 8'(f), 12'(x), 12'(y)};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_def"}, 64'(def_vec), 64'({1'b1, 1'b1, 3'b000, 8'hff, 12'd799, 12'd524}));
    check({tag, "_big"}, 64'(big_vec), 64'({1'b0, 1'b0, 3'b000, 8'hff, 12'd1055, 12'd627}));
    check({tag, "_sml"}, 64'(sml_vec), 64'({1'b0, 1'b0, 3'b000, 8'hff, 12'd13, 12'd9}));
  endtask

  task automatic check_position(input int p);
    logic [36:0] e_def, e_big, e_sml;
    e_def = raster(p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    e_big = raster(p, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
    e_sml = raster(p, 8, 2, 2, 2, 6, 1, 1, 2, 1'b1, 1'b1);
    check($sformatf("def@%0d", p), 64'(def_vec), 64'(e_def));
    check($sformatf("big@%0d", p), 64'(big_vec), 64'(e_big));
    check($sformatf("sml@%0d", p), 64'(sml_vec), 64'(e_sml));
  endtask

  // Hand-computed checkpoints at the mode boundaries.
  task automatic check_directed(input int p);
    case (p)
      0: begin
        check("def_first_xy", 64'({def_if.pixel_x, def_if.pixel_y}), 64'({12'd0, 12'd0}));
        check("def_first_fs", 64'(def_if.frame_start), 64'(1));
        check("def_first_fc", 64'(def_if.frame_cnt), 64'(0));
        check("def_first_vo", 64'(def_if.video_on), 64'(1));
      end
      10:    check("sml_hs_on", 64'(sml_if.hsync), 64'(1));
      12:    check("sml_hs_off", 64'(sml_if.hsync), 64'(0));
      97:    check("sml_vs_pre", 64'(sml_if.vsync), 64'(0));
      98:    check("sml_vs_on", 64'(sml_if.vsync), 64'(1));
      111:   check("sml_vs_hold", 64'(sml_if.vsync), 64'(1));
      112:   check("sml_vs_off", 64'(sml_if.vsync), 64'(0));
      139:   check("sml_last_xy", 64'({sml_if.pixel_x, sml_if.pixel_y}), 64'({12'd13, 12'd9}));
      140: begin
        check("sml_f1_fs", 64'(sml_if.frame_start), 64'(1));
        check("sml_f1_fc", 64'(sml_if.frame_cnt), 64'(1));
      end
      639:   check("def_vo_last", 64'(def_if.video_on), 64'(1));
      640:   check("def_vo_off", 64'(def_if.video_on), 64'(0));
      655:   check("def_hs_pre", 64'(def_if.hsync), 64'(1));
      656:   check("def_hs_on", 64'(def_if.hsync), 64'(0));
      751:   check("def_hs_end", 64'(def_if.hsync), 64'(0));
      752:   check("def_hs_off", 64'(def_if.hsync), 64'(1));
      799:   check("def_x799", 64'({def_if.pixel_x, def_if.pixel_y}), 64'({12'd799, 12'd0}));
      800: begin
        check("def_line1_xy", 64'({def_if.pixel_x, def_if.pixel_y}), 64'({12'd0, 12'd1}));
        check("def_line1_ls", 64'(def_if.line_start), 64'(1));
        check("def_line1_fs", 64'(def_if.frame_start), 64'(0));
      end
      840:   check("big_hs_on", 64'(big_if.hsync), 64'(1));
      968:   check("big_hs_off", 64'(big_if.hsync), 64'(0));
      1056:  check("big_line1_xy", 64'({big_if.pixel_x, big_if.pixel_y}), 64'({12'd0, 12'd1}));
      35839: check("sml_fc_255", 64'(sml_if.frame_cnt), 64'(255));
      35840: begin
        check("sml_fc_wrap", 64'(sml_if.frame_cnt), 64'(0));
        check("sml_wrap_fs", 64'(sml_if.frame_start), 64'(1));
      end
      default: ;
    endcase
  endtask

  // Advance one pixel; with CE the enable pulses once and the outputs must hold
  // for the remaining clocks of the stretched pixel.
  task automatic step_pixel(input int p);
    for (int j = 0; j < Div; j++) begin
`ifdef VGA_TIMING_CE_EN
      pix_ce_r = (j == 0);
`endif
      @(posedge clk);
      #1;
      check_position(p);
      if (j == 0) check_directed(p);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
`ifdef VGA_TIMING_CE_EN
    pix_ce_r = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("rel");

    for (int p = 0; p < NPos; p++) begin
      step_pixel(p);
    end

    // Asynchronous reset between clock edges takes effect without a clock.
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async");
    @(posedge clk);
    #1;
    check_reset_state("async_hold");
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step_pixel(p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
